// File: rtl/olo_intf_led_player_if.sv
// Valid/ready word stream feeding the LED player.
// Signal names follow the player's In_* port set.
interface olo_intf_led_player_if #(
  parameter int Width_g = 4
);
  logic [Width_g-1:0] In_Data;
  logic               In_Valid;
  logic               In_Ready;

  modport master (
    output In_Data,
    output In_Valid,
    input  In_Ready
  );

  modport slave (
    input  In_Data,
    input  In_Valid,
    output In_Ready
  );
endinterface

// File: rtl/olo_intf_led_player.sv
// Timed stream-to-LED player: shows each accepted word for a fixed
// on-time, blanks the LEDs for a gap time, then takes the next word.
module olo_intf_led_player #(
  parameter real ClkFrequency_g = 125.0e6,
  parameter real OnTime_g       = 0.5,
  parameter real GapTime_g      = 0.1,
  parameter int  Width_g        = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  olo_intf_led_player_if.slave in_bus,
  input  logic                 Enable,
  output logic [Width_g-1:0]   Led,
  output logic                 Busy
);

  // Small tolerance keeps exact products like 3.0000000001 from rounding up
  localparam real OnRealC  = ClkFrequency_g * OnTime_g;
  localparam real GapRealC = ClkFrequency_g * GapTime_g;
  localparam int  OnRawC   = int'($ceil(OnRealC - 1.0e-6));
  localparam int  GapRawC  = int'($ceil(GapRealC - 1.0e-6));
  localparam int  OnCyclesC  = (OnRawC < 1) ? 1 : OnRawC;
  localparam int  GapCyclesC = (GapRawC < 0) ? 0 : GapRawC;

  localparam int  MaxC  = (OnCyclesC > GapCyclesC) ? OnCyclesC : GapCyclesC;
  localparam int  CntWC = $clog2((MaxC > 2) ? MaxC : 2);

  localparam logic [CntWC-1:0] OnLoadC  = CntWC'(OnCyclesC - 1);
  localparam logic [CntWC-1:0] GapLoadC =
    (GapCyclesC > 0) ? CntWC'(GapCyclesC - 1) : '0;

  typedef enum logic [1:0] {
    Idle,
    Show,
    Gap
  } state_t;

  state_t             state_q, state_d;
  logic [CntWC-1:0]   cnt_q, cnt_d;
  logic [Width_g-1:0] led_q, led_d;
  logic               busy_q, busy_d;
  logic               ready;

  assign ready           = (state_q == Idle) && Enable && !Rst;
  assign in_bus.In_Ready = ready;
  assign Led             = led_q;
  assign Busy            = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    busy_d  = busy_q;
    unique case (state_q)
      Idle: begin
        if (ready && in_bus.In_Valid) begin
          state_d = Show;
          led_d   = in_bus.In_Data;
          busy_d  = 1'b1;
          cnt_d   = OnLoadC;
        end
      end
      Show: begin
        if (cnt_q == '0) begin
          led_d = '0;
          if (GapCyclesC > 0) begin
            state_d = Gap;
            cnt_d   = GapLoadC;
          end else begin
            state_d = Idle;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      Gap: begin
        if (cnt_q == '0) begin
          state_d = Idle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = Idle;
        led_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= Idle;
      cnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

endmodule
